// File: rtl/word_align_ctrl.sv
// 8b10b word-alignment / link-sync controller: comma hunt, boundary slips, lock qualification, loss of sync.
// Optional saturating bad-word counter on err_cnt_o when ERR_CNT_EN is defined.
module word_align_ctrl #(
  parameter int SLIP_TIMEOUT = 16,
  parameter int SLIP_BLANK   = 2,
  parameter int ACQ_WORDS    = 4,
  parameter int LOS_ERRS     = 4,
  parameter int GOOD_RUN     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        word_valid_i,
  input  logic [8:0]  word_i,
  input  logic        code_err_i,
  input  logic        disp_err_i,
  output logic        slip_o,
  output logic        sync_o,
  output logic [1:0]  state_o,
  output logic [7:0]  data_o,
  output logic        k_o,
  output logic        data_valid_o,
  input  logic        err_cnt_clr_i,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {HUNT = 2'd0, ACQ = 2'd1, SYNC = 2'd2, SLIP = 2'd3} state_e;

  localparam int MISS_W  = $clog2(SLIP_TIMEOUT + 1);
  localparam int BLANK_W = $clog2(SLIP_BLANK + 1);
  localparam int ACQ_W   = $clog2(ACQ_WORDS + 1);
  localparam int BAD_W   = $clog2(LOS_ERRS + 1);
  localparam int GOOD_W  = $clog2(GOOD_RUN + 1);

  // Counters compare against "last" values so they clear on the transition instead of wrapping.
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(SLIP_TIMEOUT - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(SLIP_BLANK - 1);
  localparam logic [ACQ_W-1:0]   ACQ_LAST   = ACQ_W'(ACQ_WORDS - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(LOS_ERRS - 1);
  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(GOOD_RUN - 1);

  state_e             state_q, state_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [ACQ_W-1:0]   acq_q, acq_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               slip_q, slip_d;
  logic               dv_q, dv_d;
  logic [7:0]         data_q, data_d;
  logic               k_q, k_d;

  logic err, comma, word_en;
  assign err     = code_err_i | disp_err_i;
  assign comma   = (word_i == 9'h1BC) && !err;
  assign word_en = enable_i && word_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      miss_q  <= '0;
      blank_q <= '0;
      acq_q   <= '0;
      bad_q   <= '0;
      good_q  <= '0;
      slip_q  <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      blank_q <= blank_d;
      acq_q   <= acq_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      slip_q  <= slip_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    blank_d = blank_q;
    acq_d   = acq_q;
    bad_d   = bad_q;
    good_d  = good_q;
    if (!enable_i) begin
      state_d = HUNT;
      miss_d  = '0;
      blank_d = '0;
      acq_d   = '0;
      bad_d   = '0;
      good_d  = '0;
    end else if (word_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (comma) begin
            miss_d = '0;
            if (ACQ_WORDS == 1) begin
              state_d = SYNC;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              state_d = ACQ;
              acq_d   = ACQ_W'(1);
            end
          end else if (miss_q == MISS_LAST) begin
            state_d = SLIP;
            miss_d  = '0;
            blank_d = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        SLIP: begin
          if (blank_q == BLANK_LAST) begin
            state_d = HUNT;
            blank_d = '0;
            miss_d  = '0;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        ACQ: begin
          if (err) begin
            state_d = HUNT;
            acq_d   = '0;
            miss_d  = '0;
          end else if (acq_q == ACQ_LAST) begin
            state_d = SYNC;
            acq_d   = '0;
            bad_d   = '0;
            good_d  = '0;
          end else begin
            acq_d = acq_q + 1'b1;
          end
        end
        SYNC: begin
          if (err) begin
            good_d = '0;
            if (bad_q == BAD_LAST) begin
              state_d = HUNT;
              bad_d   = '0;
              miss_d  = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else if (good_q == GOOD_LAST) begin
            good_d = '0;
            bad_d  = (bad_q != '0) ? bad_q - 1'b1 : '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    slip_d = word_en && (state_q == HUNT) && !comma && (miss_q == MISS_LAST);
    dv_d   = word_en && (state_q == SYNC);
    data_d = dv_d ? word_i[7:0] : data_q;
    k_d    = dv_d ? word_i[8]   : k_q;
  end

  assign slip_o       = slip_q;
  assign sync_o       = (state_q == SYNC);
  assign state_o      = state_q;
  assign data_o       = data_q;
  assign k_o          = k_q;
  assign data_valid_o = dv_q;

`ifdef ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_q <= '0;
    end else if (word_en && err && (state_q == ACQ || state_q == SYNC) && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = err_cnt_clr_i;
  assign err_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_word_align_ctrl.sv
// Self-checking bench for word_align_ctrl: directed link scenarios plus random traffic,
// every cycle compared against a word-level behavioural model.
module tb_word_align_ctrl;

  localparam int SLIP_TIMEOUT = 16;
  localparam int SLIP_BLANK   = 2;
  localparam int ACQ_WORDS    = 4;
  localparam int LOS_ERRS     = 4;
  localparam int GOOD_RUN     = 4;
`ifdef ERR_CNT_EN
  localparam bit ECE = 1'b1;
`else
  localparam bit ECE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b1;
  logic        word_valid_i = 1'b0;
  logic [8:0]  word_i = '0;
  logic        code_err_i = 1'b0;
  logic        disp_err_i = 1'b0;
  logic        err_cnt_clr_i = 1'b0;
  logic        slip_o, sync_o, k_o, data_valid_o;
  logic [1:0]  state_o;
  logic [7:0]  data_o;
  logic [15:0] err_cnt_o;

  word_align_ctrl #(
    .SLIP_TIMEOUT(SLIP_TIMEOUT), .SLIP_BLANK(SLIP_BLANK), .ACQ_WORDS(ACQ_WORDS),
    .LOS_ERRS(LOS_ERRS), .GOOD_RUN(GOOD_RUN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .word_valid_i(word_valid_i),
    .word_i(word_i), .code_err_i(code_err_i), .disp_err_i(disp_err_i),
    .slip_o(slip_o), .sync_o(sync_o), .state_o(state_o), .data_o(data_o), .k_o(k_o),
    .data_valid_o(data_valid_o), .err_cnt_clr_i(err_cnt_clr_i), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: plain integers, one update per clock.
  int m_st, m_miss, m_blank, m_acq, m_bad, m_good, m_ecnt, m_data, m_k;
  bit m_slip, m_dv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_miss = 0; m_blank = 0; m_acq = 0; m_bad = 0; m_good = 0;
    m_ecnt = 0; m_data = 0; m_k = 0; m_slip = 0; m_dv = 0;
  endtask

  task automatic model_step(input bit v, input logic [8:0] w, input bit ce, input bit de,
                            input bit en, input bit clr);
    bit err, comma;
    int cur;
    err   = ce | de;
    comma = (w == 9'h1BC) && !err;
    cur   = m_st;
    m_slip = 0;
    m_dv   = 0;
    if (!en) begin
      m_st = 0; m_miss = 0; m_blank = 0; m_acq = 0; m_bad = 0; m_good = 0;
    end else if (v) begin
      if (ECE && err && (cur == 1 || cur == 2) && m_ecnt < 65535) m_ecnt++;
      case (cur)
        0: if (comma) begin
             m_miss = 0;
             if (ACQ_WORDS == 1) begin m_st = 2; m_bad = 0; m_good = 0; end
             else begin m_st = 1; m_acq = 1; end
           end else begin
             m_miss++;
             if (m_miss == SLIP_TIMEOUT) begin m_slip = 1; m_st = 3; m_blank = 0; m_miss = 0; end
           end
        3: begin
             m_blank++;
             if (m_blank == SLIP_BLANK) begin m_st = 0; m_miss = 0; m_blank = 0; end
           end
        1: if (err) begin m_st = 0; m_miss = 0; m_acq = 0; end
           else begin
             m_acq++;
             if (m_acq == ACQ_WORDS) begin m_st = 2; m_bad = 0; m_good = 0; m_acq = 0; end
           end
        default: begin
             m_dv = 1; m_data = w[7:0]; m_k = w[8];
             if (err) begin
               m_good = 0; m_bad++;
               if (m_bad == LOS_ERRS) begin m_st = 0; m_miss = 0; m_bad = 0; end
             end else begin
               m_good++;
               if (m_good == GOOD_RUN) begin m_good = 0; if (m_bad > 0) m_bad--; end
             end
           end
      endcase
    end
    if (ECE && clr) m_ecnt = 0;
  endtask

  task automatic compare_all();
    check("state", 32'(state_o), 32'(m_st));
    check("slip", 32'(slip_o), 32'(m_slip));
    check("data_valid", 32'(data_valid_o), 32'(m_dv));
    check("sync", 32'(sync_o), 32'(m_st == 2));
    check("data", 32'(data_o), 32'(m_data));
    check("k", 32'(k_o), 32'(m_k));
    check("err_cnt", 32'(err_cnt_o), 32'(m_ecnt));
  endtask

  task automatic step(input bit v, input logic [8:0] w, input bit ce, input bit de,
                      input bit en, input bit clr);
    @(negedge clk_i);
    word_valid_i = v; word_i = w; code_err_i = ce; disp_err_i = de;
    enable_i = en; err_cnt_clr_i = clr;
    @(posedge clk_i);
    #1;
    model_step(v, w, ce, de, en, clr);
    compare_all();
  endtask

  task automatic word(input logic [8:0] w, input bit ce, input bit de);
    step(1'b1, w, ce, de, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset between edges: outputs must drop without waiting for a clock.
  task automatic async_reset();
    @(negedge clk_i);
    word_valid_i = 0; code_err_i = 0; disp_err_i = 0; err_cnt_clr_i = 0; enable_i = 1;
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic go_sync();
    for (int i = 0; i < ACQ_WORDS; i++) word(9'h1BC, 0, 0);
  endtask

  int slips;
  int first_dv;

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    compare_all();
    rst_i = 1'b0;

    // Commas every word: lock after ACQ_WORDS, first forwarded word is the next one.
    idle();
    first_dv = 0;
    for (int i = 1; i <= 8; i++) begin
      word(9'h1BC, 0, 0);
      if (data_valid_o && first_dv == 0) first_dv = i;
    end
    check("first_dv_word", 32'(first_dv), 32'(ACQ_WORDS + 1));

    // No comma: slips after word 16 and word 34.
    async_reset();
    slips = 0;
    for (int i = 1; i <= 40; i++) begin
      word(9'h0AA, 0, 0);
      if (slip_o) begin
        slips++;
        check("slip_pos", 32'(i), (slips == 1) ? 32'd16 : 32'd34);
      end
      idle();
    end
    check("slip_count", 32'(slips), 32'd2);

    // Errors spaced two apart in SYNC: four of them drop the link.
    async_reset();
    go_sync();
    for (int i = 0; i < 4; i++) begin
      word(9'h055, 1, 0);
      word(9'h0F0, 0, 0);
    end
    check("los_state", 32'(state_o), 32'd0);

    // Three errors then twelve clean words: score recovers, sync held, then 3 errors survive.
    async_reset();
    go_sync();
    for (int i = 0; i < 3; i++) word(9'h011, 0, 1);
    for (int i = 0; i < 12; i++) word(9'(i), 0, 0);
    for (int i = 0; i < 3; i++) word(9'h13C, 1, 0);
    check("sync_held", 32'(sync_o), 32'd1);

    // Disparity error in ACQ, then enable drop from SYNC.
    word(9'h1BC, 0, 0);
    async_reset();
    word(9'h1BC, 0, 0);
    word(9'h0C3, 0, 1);
    check("acq_abort", 32'(state_o), 32'd0);
    go_sync();
    step(1'b1, 9'h077, 0, 0, 1'b0, 1'b0);
    check("enable_hunt", 32'(state_o), 32'd0);

    // Error counter: five errored words in SYNC, then clear coincident with a sixth.
    async_reset();
    go_sync();
    for (int i = 0; i < 5; i++) begin
      word(9'h0E7, 1, 0);
      for (int j = 0; j < GOOD_RUN; j++) word(9'h0A5, 0, 0);
    end
    check("err_cnt_5", 32'(err_cnt_o), ECE ? 32'd5 : 32'd0);
    step(1'b1, 9'h0E7, 1, 0, 1'b1, 1'b1);
    check("err_cnt_clr", 32'(err_cnt_o), 32'd0);

    // Random traffic with idle gaps, enable drops, clears and a mid-run reset.
    for (int n = 0; n < 4000; n++) begin
      bit v, ce, de, en, clr;
      logic [8:0] w;
      v   = ($urandom_range(0, 9) < 7);
      w   = ($urandom_range(0, 9) < 5) ? 9'h1BC : 9'($urandom);
      ce  = ($urandom_range(0, 99) < 5);
      de  = ($urandom_range(0, 99) < 4);
      en  = ($urandom_range(0, 99) >= 2);
      clr = ($urandom_range(0, 99) < 3);
      step(v, w, ce, de, en, clr);
      if (n == 2000) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
